// File: rtl/lsu_ctrl.sv
// Load/store controller: one data-memory access per request over a req/ready handshake.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of ignoring low offset bits.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        illegal_f3;
  logic        misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [15:0] cnt_inc;

  assign accept     = start & (is_load | is_store);
  assign illegal_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane placement from the live request; sub-natural offset bits are simply ignored.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr[1:0];
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    case (addr_lo_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latches).
    state_d     = state_q;
    store_d     = store_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d     = 16'd0;
          store_d   = is_store;
          f3_d      = funct3;
          addr_lo_d = addr[1:0];
          if (illegal_f3 || misalign) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            err_d       = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b0;
          if (!store_q) rdata_d = load_ext;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      f3_q        <= 3'd0;
      addr_lo_q   <= 2'd0;
      cnt_q       <= 16'd0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign stall     = start & ~done;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses against a
// transaction-level reference model (expected lanes, extension, latency and error outcome).
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata = 32'd0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done), .err(err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access: cycle 0 presents the request, memory answers at cycle delay+1.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int delay, input logic [31:0] rword);
    logic [1:0]  sz;
    logic        bad, e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, ext;
    int          k, done_c;
    sz  = f3[1:0];
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`endif
    case (sz)
      2'd0: begin
        e_be = 4'(1 << a[1:0]);
        e_wd = {4{wd[7:0]}};
        ext  = (rword >> (8 * a[1:0])) & 32'hFF;
        if (!f3[2] && ext[7]) ext = ext | 32'hFFFF_FF00;
      end
      2'd1: begin
        e_be = 4'(3 << (2 * a[1]));
        e_wd = {2{wd[15:0]}};
        ext  = (rword >> (16 * a[1])) & 32'hFFFF;
        if (!f3[2] && ext[15]) ext = ext | 32'hFFFF_0000;
      end
      default: begin
        e_be = 4'hF;
        e_wd = wd;
        ext  = rword;
      end
    endcase
    k = delay + 1;
    if (bad) begin
      done_c = 1; e_err = 1'b1; e_rd = model_rdata;
    end else if (k <= TO) begin
      done_c = k + 1; e_err = 1'b0; e_rd = st ? model_rdata : ext;
    end else begin
      done_c = TO + 1; e_err = 1'b1; e_rd = model_rdata;
    end

    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'($urandom % 2);
    mem_rdata = $urandom;
    #1 check("stall_req", stall, 1);
    for (int c = 1; c <= TO + 2; c++) begin
      @(negedge clk);
      if (!bad && c == k) begin
        mem_ready = 1'b1; mem_rdata = rword;
      end else begin
        mem_ready = (c == done_c) ? 1'($urandom % 2) : 1'b0;
        mem_rdata = $urandom;
      end
      #1;
      if (c == done_c) begin
        check("done", done, 1);
        check("err", err, e_err);
        check("rdata", rdata, e_rd);
        check("req_after", mem_req, 0);
        check("stall_done", stall, 0);
        model_rdata = e_rd;
        break;
      end
      check("done_early", done, 0);
      check("req", mem_req, !bad);
      if (c == 1 && !bad) begin
        check("addr", mem_addr, {a[31:2], 2'b00});
        check("be", mem_be, e_be);
        check("we", mem_we, st);
        if (st) check("wdata", mem_wdata, e_wd);
      end
    end
  endtask

  task automatic run_ignored(input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; is_store = 1'b0; addr = a; funct3 = 3'd2; mem_ready = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      #1;
      check("ign_req", mem_req, 0);
      check("ign_done", done, 0);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40; mem_ready = 1'b0;
    @(negedge clk);
    #1 check("rst_req_on", mem_req, 1);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check("rst_req_off", mem_req, 0);
    check("rst_no_done", done, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("rst_no_done2", done, 0);
    model_rdata = 32'd0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata0", rdata, 0);
    @(negedge clk);
    reset = 1'b0;

    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0);
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF1234);
    run_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80FF1234);
    run_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 32'h80017FFF);
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h0);
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'hCAFEF00D);
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 20, 32'h0);
    run_access(1'b1, 1'b1, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0);
    run_access(1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 0, 32'h0);
    run_access(1'b0, 1'b1, 3'b100, 32'h300, 32'h0, 0, 32'h0);
    run_ignored(32'h500);
    reset_mid_access();
    run_access(1'b1, 1'b0, 3'b101, 32'h406, 32'h0, 1, 32'hBEEF1111);

    for (int i = 0; i < 200; i++) begin
      logic ld, st;
      int   kind, dly;
      kind = $urandom % 3;
      ld   = (kind != 1);
      st   = (kind != 0);
      dly  = ($urandom % 4 == 0) ? TO + int'($urandom % 3) : int'($urandom % TO);
      run_access(ld, st, 3'($urandom % 8), $urandom, $urandom, dly, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
